// File: rtl/regfile_wb_queue_pkg.sv
//==============================================================================
// Module  : regfile_wb_queue_pkg
// Purpose : Shared constants and entry type for the register file writeback
//           queue and its forwarding match logic.
// Contents: c_REGS, c_N, c_ADDR_W  - architectural register file geometry
//           c_ZERO_REG             - index of the hardwired-zero register
//           wb_entry_t             - one queued write {addr, data}
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_wb_queue_pkg;

  localparam int c_REGS   = 32;
  localparam int c_N      = 32;
  localparam int c_ADDR_W = $clog2(c_REGS);

  localparam logic [c_ADDR_W-1:0] c_ZERO_REG = '0;

  typedef struct packed {
    logic [c_ADDR_W-1:0] addr;
    logic [c_N-1:0]      data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_fwd_match.sv
//==============================================================================
// Module  : regfile_wb_fwd_match
// Purpose : Combinational youngest-match search over the writeback queue.
//           Walks the entries from oldest (head) to youngest so the last
//           match found is the most recent pending write to i_addr.
// Ports   : i_entries - queue storage, indexed by physical slot
//           i_valid   - per-slot occupancy
//           i_head    - slot holding the oldest entry
//           i_addr    - register being read
//           o_hit     - a pending write to i_addr exists (never for x0)
//           o_data    - data of the youngest pending write, 0 on no hit
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wb_fwd_match
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [PTR_W-1:0]      i_head,
  input  logic [c_ADDR_W-1:0]   i_addr,
  output logic                  o_hit,
  output logic [c_N-1:0]        o_data
);

  always_comb begin
    logic [PTR_W-1:0] w_idx;
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = i_head;
    // Age order: slot head+i is older than head+i+1; later matches override.
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr) &&
          (i_addr != c_ZERO_REG)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_queue.sv
//==============================================================================
// Module  : regfile_wb_queue
// Purpose : In-order writeback buffer in front of the register file write
//           port, with two forwarding lookup ports that expose queued but
//           not yet committed writes.
// Ports   : clk, rst              - clock, async active-high reset
//           in_valid/in_ready     - write request handshake
//           in_addr/in_data       - write request payload
//           drain_en              - register file write port free this cycle
//           rf_we/rf_addr/rf_wdata- register file write port
//           fwd_addrN/fwd_hitN/fwd_dataN - forwarding lookups (N = 1, 2)
//           count/empty/full      - occupancy status
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  // The entry type is fixed by the package; REGS and N must match it.
  parameter  int REGS   = c_REGS,
  parameter  int N      = c_N,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(REGS),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [N-1:0]      in_data,
  input  logic              drain_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [N-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic [N-1:0]      fwd_data1,
  output logic              fwd_hit2,
  output logic [N-1:0]      fwd_data2,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;

  logic w_empty;
  logic w_full;
  logic w_zero_req;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL_COUNT);
  // Writes to x0 are accepted and dropped, even when the queue is full.
  assign w_zero_req = in_valid && (in_addr == c_ZERO_REG);
  assign w_push     = in_valid && !w_full && !w_zero_req;
  assign w_pop      = drain_en && !w_empty;

  assign in_ready = !w_full || w_zero_req;
  assign rf_we    = w_pop;
  assign rf_addr  = w_empty ? '0 : r_entries[r_rd_ptr].addr;
  assign rf_wdata = w_empty ? '0 : r_entries[r_rd_ptr].data;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      // Push and pop never target the same slot: that needs empty or full,
      // which block pop and push respectively.
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through r_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entries[r_wr_ptr] <= {in_addr, in_data};
    end
  end

  // Lookups see registered state only; a same-cycle request is not forwarded.
  regfile_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_rd_ptr),
    .i_addr    (fwd_addr1),
    .o_hit     (fwd_hit1),
    .o_data    (fwd_data1)
  );

  regfile_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_rd_ptr),
    .i_addr    (fwd_addr2),
    .o_hit     (fwd_hit2),
    .o_data    (fwd_data2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
//==============================================================================
// Module  : tb_regfile_wb_queue
// Purpose : Self-checking bench for regfile_wb_queue (DEPTH=4, 32 regs,
//           32-bit data): per-cycle vector table plus hand-written sequences
//           for back-pressure, x0 discard, pointer wrap and mid-run reset.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_addr1;
  logic [4:0]  fwd_addr2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  regfile_wb_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // after a further unit, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        drain;
    logic [4:0]  f1;
    logic [4:0]  f2;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic vld, input logic [4:0] addr, input logic [31:0] data,
                      input logic drain, input logic [4:0] f1, input logic [4:0] f2,
                      input logic e_rdy, input logic e_we, input logic [4:0] e_addr,
                      input logic [31:0] e_wdata, input logic e_h1, input logic [31:0] e_d1,
                      input logic e_h2, input logic [31:0] e_d2, input logic [2:0] e_cnt);
    vec_t v;
    v = '{vld, addr, data, drain, f1, f2, e_rdy, e_we, e_addr, e_wdata, e_h1, e_d1, e_h2, e_d2, e_cnt};
    vecs.push_back(v);
  endtask

  logic [4:0]  c_addr[$];
  logic [31:0] c_data[$];
  int          n_writes;
  logic        acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // ---- reset state ----
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.hit1", 32'(fwd_hit1), 32'd0);

    // ---- per-cycle vector table (expected = state before the cycle's edge) ----
    // basic drain
    addv(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd6,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  3'd1);
    addv(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd6,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    // youngest-wins forwarding; in-flight request not forwarded
    addv(1'b1, 5'd7, 32'h11,       1'b0, 5'd7, 5'd8,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    addv(1'b1, 5'd7, 32'h22,       1'b0, 5'd7, 5'd8,  1'b1, 1'b0, 5'd7, 32'h11,       1'b1, 32'h11,       1'b0, 32'h0,  3'd1);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd8,  1'b1, 1'b1, 5'd7, 32'h11,       1'b1, 32'h22,       1'b0, 32'h0,  3'd2);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd8,  1'b1, 1'b1, 5'd7, 32'h22,       1'b1, 32'h22,       1'b0, 32'h0,  3'd1);
    addv(1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    // x0 write is dropped
    addv(1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    // two ports hitting different registers
    addv(1'b1, 5'd3, 32'hAA,       1'b0, 5'd3, 5'd9,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);
    addv(1'b1, 5'd9, 32'hBB,       1'b0, 5'd3, 5'd9,  1'b1, 1'b0, 5'd3, 32'hAA,       1'b1, 32'hAA,       1'b0, 32'h0,  3'd1);
    addv(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd9,  1'b1, 1'b0, 5'd3, 32'hAA,       1'b1, 32'hAA,       1'b1, 32'hBB, 3'd2);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd9,  1'b1, 1'b1, 5'd3, 32'hAA,       1'b1, 32'hAA,       1'b1, 32'hBB, 3'd2);
    addv(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd9,  1'b1, 1'b1, 5'd9, 32'hBB,       1'b0, 32'h0,        1'b1, 32'hBB, 3'd1);
    addv(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd9,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].vld; in_addr = vecs[i].addr; in_data = vecs[i].data;
      drain_en = vecs[i].drain; fwd_addr1 = vecs[i].f1; fwd_addr2 = vecs[i].f2;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.rf_we", i),    32'(rf_we),    32'(vecs[i].e_we));
      chk($sformatf("v%0d.rf_addr", i),  32'(rf_addr),  32'(vecs[i].e_addr));
      chk($sformatf("v%0d.rf_wdata", i), rf_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d.hit1", i),     32'(fwd_hit1), 32'(vecs[i].e_h1));
      chk($sformatf("v%0d.data1", i),    fwd_data1,     vecs[i].e_d1);
      chk($sformatf("v%0d.hit2", i),     32'(fwd_hit2), 32'(vecs[i].e_h2));
      chk($sformatf("v%0d.data2", i),    fwd_data2,     vecs[i].e_d2);
      chk($sformatf("v%0d.count", i),    32'(count),    32'(vecs[i].e_cnt));
      tick();
    end
    in_valid = 1'b0; drain_en = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;

    // ---- full / back-pressure / x0 discard while full ----
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_addr = 5'd5; in_data = 32'h105;
    #1;
    chk("bp.full", 32'(full), 32'd1);
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    chk("bp.count", 32'(count), 32'd4);
    tick();
    chk("bp.held_count", 32'(count), 32'd4);
    in_addr = 5'd0; in_data = 32'h1234; fwd_addr1 = 5'd0;
    #1;
    chk("x0.in_ready_full", 32'(in_ready), 32'd1);
    chk("x0.hit1", 32'(fwd_hit1), 32'd0);
    tick();
    chk("x0.count", 32'(count), 32'd4);
    fwd_addr1 = 5'd3;
    #1;
    chk("bp.fwd3_hit", 32'(fwd_hit1), 32'd1);
    chk("bp.fwd3_data", fwd_data1, 32'h103);
    in_addr = 5'd5; in_data = 32'h105; drain_en = 1'b1;
    #1;
    chk("bp.no_ready_from_drain", 32'(in_ready), 32'd0);
    c_addr.delete(); c_data.delete();
    for (int c = 0; c < 12; c++) begin
      if (rf_we) begin
        c_addr.push_back(rf_addr);
        c_data.push_back(rf_wdata);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      #1;
    end
    chk("bp.n_commits", 32'(c_addr.size()), 32'd5);
    for (int k = 0; k < 5 && k < c_addr.size(); k++) begin
      chk($sformatf("bp.commit%0d_addr", k), 32'(c_addr[k]), 32'(k + 1));
      chk($sformatf("bp.commit%0d_data", k), c_data[k], 32'h101 + 32'(k));
    end
    chk("bp.drained_empty", 32'(empty), 32'd1);

    // ---- wrap-around with a push and a pop every cycle ----
    c_addr.delete(); c_data.delete();
    drain_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      in_valid = (c < 10); in_addr = 5'(c + 1); in_data = 32'hA0 + 32'(c);
      #1;
      if (c >= 1) chk($sformatf("wrap.count%0d", c), 32'(count), 32'd1);
      if (rf_we) begin
        c_addr.push_back(rf_addr);
        c_data.push_back(rf_wdata);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap.final_count", 32'(count), 32'd0);
    chk("wrap.n_commits", 32'(c_addr.size()), 32'd10);
    for (int k = 0; k < 10 && k < c_addr.size(); k++) begin
      chk($sformatf("wrap.commit%0d_addr", k), 32'(c_addr[k]), 32'(k + 1));
      chk($sformatf("wrap.commit%0d_data", k), c_data[k], 32'hA0 + 32'(k));
    end

    // ---- asynchronous reset mid-operation ----
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h300 + 32'(i);
      tick();
    end
    in_valid = 1'b0; drain_en = 1'b1; fwd_addr1 = 5'd1;
    #1;
    chk("rst2.pre_count", 32'(count), 32'd3);
    chk("rst2.pre_rf_we", 32'(rf_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst2.count", 32'(count), 32'd0);
    chk("rst2.empty", 32'(empty), 32'd1);
    chk("rst2.rf_we", 32'(rf_we), 32'd0);
    chk("rst2.hit1", 32'(fwd_hit1), 32'd0);
    tick();
    rst = 1'b0;
    n_writes = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rf_we) n_writes++;
      tick();
    end
    chk("rst2.no_writes", 32'(n_writes), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
